// File: rtl/llc_snoop_responder.sv
// llc_snoop_responder: snoop lookup, result, upper-level messaging, writeback and MESI update for the LLC
module llc_snoop_responder #(
   parameter int WAYS   = 16,
   parameter int ADDR_W = 32,
   parameter int IDX_W  = 14,
   parameter int OFF_W  = 6,
   parameter int TAG_W  = ADDR_W - IDX_W - OFF_W,
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    snp_valid,
   output logic                    snp_ready,
   input  logic [2:0]              snp_op,
   input  logic [ADDR_W-1:0]       snp_addr,
   output logic                    ta_rd_en,
   output logic [IDX_W-1:0]        ta_rd_idx,
   input  logic [WAYS*TAG_W-1:0]   ta_rd_tag,
   input  logic [WAYS*2-1:0]       ta_rd_mesi,
   output logic                    ta_wr_en,
   output logic [IDX_W-1:0]        ta_wr_idx,
   output logic [WAY_W-1:0]        ta_wr_way,
   output logic [1:0]              ta_wr_mesi,
   output logic                    res_valid,
   output logic [1:0]              res_code,
   output logic                    msg_valid,
   input  logic                    msg_ready,
   output logic [2:0]              msg_code,
   output logic [ADDR_W-1:0]       msg_addr,
   output logic                    wb_valid,
   input  logic                    wb_ready,
   output logic [ADDR_W-1:0]       wb_addr,
   output logic                    err,
   output logic [31:0]             stat_snoops,
   output logic [31:0]             stat_hitm
);
   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_COMPARE, S_RESULT, S_GETL, S_WB, S_INVL, S_UPDATE} state_t;
   localparam logic [2:0] OP_READ = 3'd1, OP_WRITE = 3'd2, OP_INV = 3'd3, OP_RWIM = 3'd4;
   localparam logic [2:0] MSG_GETL = 3'd1, MSG_INVL = 3'd3;
   localparam logic [1:0] M_I = 2'd0, M_S = 2'd1, M_E = 2'd2, M_M = 2'd3;
   localparam logic [1:0] R_NOHIT = 2'd0, R_HIT = 2'd1, R_HITM = 2'd2;
   state_t                  r_state;
   logic [2:0]              r_op;
   logic [ADDR_W-OFF_W-1:0] r_addr;
   logic                    r_ta_rd_en, r_ta_wr_en, r_res_valid, r_msg_valid, r_wb_valid, r_err;
   logic [1:0]              r_res_code, r_new_mesi;
   logic [2:0]              r_msg_code;
   logic [WAY_W-1:0]        r_way;
   logic                    r_getl, r_inv, r_upd;
   logic [31:0]             r_stat_snoops, r_stat_hitm;
   logic [TAG_W-1:0]        w_tag;
   logic [WAYS-1:0]         w_hit_vec;
   logic [WAY_W-1:0]        w_hit_way;
   logic [1:0]              w_mesi, w_code, w_new;
   logic                    w_hit, w_multi, w_legal, w_m, w_e, w_s;
   logic                    w_rd, w_rw, w_iv, w_wr, w_getl, w_inv, w_upd, w_err;
   logic                    w_unused;
   assign w_unused  = ^snp_addr[OFF_W-1:0];
   assign w_tag     = r_addr[ADDR_W-OFF_W-1 -: TAG_W];
   assign snp_ready = (r_state == S_IDLE) && !rst;
   assign ta_rd_en  = r_ta_rd_en;
   assign ta_rd_idx = r_addr[IDX_W-1:0];
   assign ta_wr_en  = r_ta_wr_en;
   assign ta_wr_idx = r_addr[IDX_W-1:0];
   assign ta_wr_way = r_way;
   assign ta_wr_mesi = r_new_mesi;
   assign res_valid = r_res_valid;
   assign res_code  = r_res_code;
   assign msg_valid = r_msg_valid;
   assign msg_code  = r_msg_code;
   assign msg_addr  = {r_addr, {OFF_W{1'b0}}};
   assign wb_valid  = r_wb_valid;
   assign wb_addr   = {r_addr, {OFF_W{1'b0}}};
   assign err       = r_err;
   assign stat_snoops = r_stat_snoops;
   assign stat_hitm   = r_stat_hitm;
   // per-way hit vector; descending scan leaves the lowest hitting way selected
   always_comb begin
      w_hit_vec = '0;
      w_hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         w_hit_vec[w] = (ta_rd_mesi[2*w +: 2] != M_I) && (ta_rd_tag[TAG_W*w +: TAG_W] == w_tag);
         if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
      end
   end
   assign w_mesi  = ta_rd_mesi[{w_hit_way, 1'b0} +: 2];
   assign w_hit   = |w_hit_vec;
   assign w_multi = |(w_hit_vec & (w_hit_vec - WAYS'(1)));
   assign w_legal = (r_op != 3'd0) && (r_op <= OP_RWIM);
   assign w_m  = w_hit && (w_mesi == M_M);
   assign w_e  = w_hit && (w_mesi == M_E);
   assign w_s  = w_hit && (w_mesi == M_S);
   assign w_rd = r_op == OP_READ;
   assign w_rw = r_op == OP_RWIM;
   assign w_iv = r_op == OP_INV;
   assign w_wr = r_op == OP_WRITE;
   assign w_code = (w_rd || w_rw) ? (w_m ? R_HITM : w_hit ? R_HIT : R_NOHIT) : (w_iv && w_s) ? R_HIT : R_NOHIT;
   assign w_getl = (w_rd || w_rw) && w_m;
   assign w_inv  = (w_rw && w_hit) || (w_iv && w_s);
   assign w_upd  = w_inv || (w_rd && (w_m || w_e));
   assign w_new  = w_rd ? M_S : M_I;
   assign w_err  = !w_legal || w_multi || (w_iv && w_hit && !w_s) || (w_wr && w_hit);
   // snoop sequencer: every output is a register so reset clears it at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_op          <= '0;
         r_addr        <= '0;
         r_ta_rd_en    <= 1'b0;
         r_ta_wr_en    <= 1'b0;
         r_res_valid   <= 1'b0;
         r_res_code    <= '0;
         r_msg_valid   <= 1'b0;
         r_msg_code    <= '0;
         r_wb_valid    <= 1'b0;
         r_err         <= 1'b0;
         r_way         <= '0;
         r_new_mesi    <= '0;
         r_getl        <= 1'b0;
         r_inv         <= 1'b0;
         r_upd         <= 1'b0;
         r_stat_snoops <= '0;
         r_stat_hitm   <= '0;
      end else begin
         r_ta_rd_en  <= 1'b0;
         r_ta_wr_en  <= 1'b0;
         r_res_valid <= 1'b0;
         r_err       <= 1'b0;
         case (r_state)
            S_IDLE: if (snp_valid) begin
               r_op          <= snp_op;
               r_addr        <= snp_addr[ADDR_W-1:OFF_W];
               r_ta_rd_en    <= (snp_op != 3'd0) && (snp_op <= OP_RWIM);
               r_stat_snoops <= r_stat_snoops + 32'd1;
               r_state       <= S_LOOKUP;
            end
            S_LOOKUP: r_state <= S_COMPARE;
            S_COMPARE: begin
               r_res_valid <= 1'b1;
               r_res_code  <= w_code;
               r_err       <= w_err;
               r_way       <= w_hit_way;
               r_new_mesi  <= w_new;
               r_getl      <= w_getl;
               r_inv       <= w_inv;
               r_upd       <= w_upd;
               if (w_code == R_HITM) r_stat_hitm <= r_stat_hitm + 32'd1;
               r_state     <= S_RESULT;
            end
            S_RESULT: begin
               r_msg_valid <= r_getl || r_inv;
               r_msg_code  <= r_getl ? MSG_GETL : r_inv ? MSG_INVL : r_msg_code;
               r_ta_wr_en  <= !r_getl && !r_inv && r_upd;
               r_state     <= r_getl ? S_GETL : r_inv ? S_INVL : r_upd ? S_UPDATE : S_IDLE;
            end
            S_GETL: if (msg_ready) begin
               r_msg_valid <= 1'b0;
               r_wb_valid  <= 1'b1;
               r_state     <= S_WB;
            end
            S_WB: if (wb_ready) begin
               r_wb_valid  <= 1'b0;
               r_msg_valid <= r_inv;
               r_msg_code  <= r_inv ? MSG_INVL : r_msg_code;
               r_ta_wr_en  <= !r_inv;
               r_state     <= r_inv ? S_INVL : S_UPDATE;
            end
            S_INVL: if (msg_ready) begin
               r_msg_valid <= 1'b0;
               r_ta_wr_en  <= 1'b1;
               r_state     <= S_UPDATE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_llc_snoop_responder.sv
// tb_llc_snoop_responder: scoreboard bench with a rule-level MESI snoop model
module tb_llc_snoop_responder;
   localparam int WAYS = 16, TAG_W = 12;
   localparam int EV_RD = 0, EV_RES = 1, EV_MSG = 2, EV_WB = 3, EV_WR = 4;
   typedef struct {int k; logic [31:0] a; int b; int c;} ev_t;
   logic clk = 0, rst = 1;
   logic snp_valid = 0, snp_ready;
   logic [2:0] snp_op = 0;
   logic [31:0] snp_addr = 0;
   logic ta_rd_en, ta_wr_en;
   logic [13:0] ta_rd_idx, ta_wr_idx;
   logic [WAYS*TAG_W-1:0] ta_rd_tag = 0;
   logic [WAYS*2-1:0] ta_rd_mesi = 0;
   logic [3:0] ta_wr_way;
   logic [1:0] ta_wr_mesi, res_code;
   logic res_valid, msg_valid, msg_ready = 0, wb_valid, wb_ready = 0, err;
   logic [2:0] msg_code;
   logic [31:0] msg_addr, wb_addr, stat_snoops, stat_hitm;
   logic [TAG_W-1:0] set_tag [WAYS];
   logic [1:0] set_mesi [WAYS];
   ev_t q[$];
   int n_pass = 0, n_total = 0, cyc = 0, acc = 0, err_total = 0, exp_err_total = 0;
   logic [31:0] exp_snoops = 0, exp_hitm = 0;
   bit hold_msg = 0, hold_wb = 0, rd_seen = 0;

   llc_snoop_responder dut (
      .clk(clk), .rst(rst), .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
      .ta_rd_en(ta_rd_en), .ta_rd_idx(ta_rd_idx), .ta_rd_tag(ta_rd_tag), .ta_rd_mesi(ta_rd_mesi),
      .ta_wr_en(ta_wr_en), .ta_wr_idx(ta_wr_idx), .ta_wr_way(ta_wr_way), .ta_wr_mesi(ta_wr_mesi),
      .res_valid(res_valid), .res_code(res_code), .msg_valid(msg_valid), .msg_ready(msg_ready),
      .msg_code(msg_code), .msg_addr(msg_addr), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
      .err(err), .stat_snoops(stat_snoops), .stat_hitm(stat_hitm));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic got(input int k, input logic [31:0] a, input int b, input int c, input string nm);
      ev_t e;
      if (q.size() == 0) begin
         n_total++;
         $display("FAIL %s: unexpected event kind %0d a=%0h b=%0d c=%0d, expected none", nm, k, a, b, c);
      end else begin
         e = q.pop_front();
         chk({nm, "_kind"}, k, e.k);
         chk({nm, "_a"}, a, e.a);
         chk({nm, "_b"}, b, e.b);
         chk({nm, "_c"}, c, e.c);
      end
   endtask

   // tag array: real set contents exactly one cycle after a read request, noise otherwise
   initial forever begin
      @(negedge clk);
      rd_seen = ta_rd_en;
      @(posedge clk);
      #1;
      for (int w = 0; w < WAYS; w++) begin
         ta_rd_tag[w*TAG_W +: TAG_W] = rd_seen ? set_tag[w] : TAG_W'($urandom);
         ta_rd_mesi[w*2 +: 2] = rd_seen ? set_mesi[w] : 2'($urandom);
      end
   end

   // random backpressure on the message and writeback channels
   initial forever begin
      @(posedge clk);
      #2;
      msg_ready = hold_msg ? 1'b0 : ($urandom_range(0, 3) != 0);
      wb_ready  = hold_wb ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   // monitor: pops expected events and checks hold stability
   initial begin
      bit pm = 0, pw = 0;
      logic [2:0] pcode = 0;
      logic [31:0] pmaddr = 0, pwaddr = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pm = 0;
            pw = 0;
         end else begin
            err_total += int'(err);
            if (pm) begin
               chk("msg_valid_held", msg_valid, 1);
               chk("msg_code_stable", msg_code, pcode);
               chk("msg_addr_stable", msg_addr, pmaddr);
            end
            if (pw) begin
               chk("wb_valid_held", wb_valid, 1);
               chk("wb_addr_stable", wb_addr, pwaddr);
            end
            pm = msg_valid && !msg_ready;
            pw = wb_valid && !wb_ready;
            pcode = msg_code;
            pmaddr = msg_addr;
            pwaddr = wb_addr;
            if (ta_rd_en) got(EV_RD, 32'(ta_rd_idx), 0, 0, "rd");
            if (res_valid) begin
               got(EV_RES, 0, int'(res_code), 0, "res");
               chk("res_cycle", cyc - acc, 3);
            end
            if (msg_valid && msg_ready) got(EV_MSG, msg_addr, int'(msg_code), 0, "msg");
            if (wb_valid && wb_ready) got(EV_WB, wb_addr, 0, 0, "wb");
            if (ta_wr_en) got(EV_WR, 32'(ta_wr_idx), int'(ta_wr_way), int'(ta_wr_mesi), "wr");
         end
      end
   end

   // reference model: MESI snoop rules applied to the current set contents
   task automatic model(input logic [2:0] op, input logic [31:0] addr, input bit cut, output bit fast);
      logic [11:0] t;
      logic [31:0] ln, ix;
      int hw, nh, m;
      bit e;
      ev_t evs[$];
      t = addr[31:20];
      ln = addr & 32'hFFFF_FFC0;
      ix = 32'(addr[19:6]);
      hw = -1;
      nh = 0;
      for (int w = 0; w < WAYS; w++)
         if (set_mesi[w] != 0 && set_tag[w] == t) begin
            nh++;
            if (hw < 0) hw = w;
         end
      m = hw >= 0 ? int'(set_mesi[hw]) : 0;
      e = 0;
      if (op < 1 || op > 4) begin
         evs.push_back('{EV_RES, 0, 0, 0});
         e = 1;
      end else begin
         evs.push_back('{EV_RD, ix, 0, 0});
         e = nh > 1;
         case (op)
            3'd1: if (m == 3) begin
               evs.push_back('{EV_RES, 0, 2, 0}); evs.push_back('{EV_MSG, ln, 1, 0});
               evs.push_back('{EV_WB, ln, 0, 0}); evs.push_back('{EV_WR, ix, hw, 1});
            end else if (m == 2) begin
               evs.push_back('{EV_RES, 0, 1, 0}); evs.push_back('{EV_WR, ix, hw, 1});
            end else evs.push_back('{EV_RES, 0, m == 1 ? 1 : 0, 0});
            3'd4: if (m == 3) begin
               evs.push_back('{EV_RES, 0, 2, 0}); evs.push_back('{EV_MSG, ln, 1, 0});
               evs.push_back('{EV_WB, ln, 0, 0}); evs.push_back('{EV_MSG, ln, 3, 0});
               evs.push_back('{EV_WR, ix, hw, 0});
            end else if (m != 0) begin
               evs.push_back('{EV_RES, 0, 1, 0}); evs.push_back('{EV_MSG, ln, 3, 0});
               evs.push_back('{EV_WR, ix, hw, 0});
            end else evs.push_back('{EV_RES, 0, 0, 0});
            3'd3: if (m == 1) begin
               evs.push_back('{EV_RES, 0, 1, 0}); evs.push_back('{EV_MSG, ln, 3, 0});
               evs.push_back('{EV_WR, ix, hw, 0});
            end else begin
               evs.push_back('{EV_RES, 0, 0, 0});
               if (m != 0) e = 1;
            end
            default: begin
               evs.push_back('{EV_RES, 0, 0, 0});
               if (nh > 0) e = 1;
            end
         endcase
      end
      if (m == 3 && (op == 1 || op == 4)) exp_hitm++;
      fast = 1;
      foreach (evs[i]) if (evs[i].k == EV_MSG || evs[i].k == EV_WR) fast = 0;
      if (cut) while (evs.size() > 0 && evs[$].k != EV_MSG) void'(evs.pop_back());
      exp_err_total += int'(e);
      foreach (evs[i]) q.push_back(evs[i]);
   endtask

   task automatic set_line(input logic [31:0] addr, input int way, input logic [1:0] mesi);
      for (int w = 0; w < WAYS; w++) begin
         set_tag[w] = addr[31:20] ^ 12'($urandom_range(1, 4095));
         set_mesi[w] = 2'($urandom);
      end
      if (way >= 0) begin
         set_tag[way] = addr[31:20];
         set_mesi[way] = mesi;
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_snp_ready"}, snp_ready, 0);
      chk({nm, "_res_valid"}, res_valid, 0);
      chk({nm, "_msg_valid"}, msg_valid, 0);
      chk({nm, "_wb_valid"}, wb_valid, 0);
      chk({nm, "_ta_rd_en"}, ta_rd_en, 0);
      chk({nm, "_ta_wr_en"}, ta_wr_en, 0);
      chk({nm, "_err"}, err, 0);
      chk({nm, "_msg_code"}, msg_code, 0);
      chk({nm, "_res_code"}, res_code, 0);
      chk({nm, "_msg_addr"}, msg_addr, 0);
      chk({nm, "_wb_addr"}, wb_addr, 0);
      chk({nm, "_ta_rd_idx"}, 32'(ta_rd_idx), 0);
      chk({nm, "_ta_wr_idx"}, 32'(ta_wr_idx), 0);
      chk({nm, "_stat_snoops"}, stat_snoops, 0);
      chk({nm, "_stat_hitm"}, stat_hitm, 0);
   endtask

   // issue one snoop from a negedge; rst_mode resets the block while it waits on the writeback
   task automatic do_snoop(input logic [2:0] op, input logic [31:0] addr, input bit rst_mode);
      bit fast;
      int n;
      model(op, addr, rst_mode, fast);
      exp_snoops++;
      snp_valid = 1;
      snp_op = op;
      snp_addr = addr;
      n = 0;
      while (!snp_ready && n < 50) begin @(negedge clk); n++; end
      chk("accept_ready", snp_ready, 1);
      acc = cyc;
      @(negedge clk);
      snp_valid = 0;
      snp_op = 3'($urandom);
      snp_addr = $urandom;
      if (rst_mode) begin
         n = 0;
         while (!wb_valid && n < 100) begin @(negedge clk); n++; end
         chk("wb_wait", wb_valid, 1);
         repeat (2) @(negedge clk);
         rst = 1;
         #1;
         chk_zero("rst_wb");
         exp_snoops = 0;
         exp_hitm = 0;
         @(negedge clk);
         chk("rst_no_wr", ta_wr_en, 0);
         rst = 0;
         hold_wb = 0;
         @(negedge clk);
         chk("ready_after_rst", snp_ready, 1);
      end else begin
         n = 0;
         while (!snp_ready && n < 200) begin @(negedge clk); n++; end
         chk("done_ready", snp_ready, 1);
         if (fast) chk("ready_cycle", cyc - acc, 4);
      end
      chk("events_left", q.size(), 0);
      chk("err_count", err_total, exp_err_total);
      chk("stat_snoops", stat_snoops, exp_snoops);
      chk("stat_hitm", stat_hitm, exp_hitm);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      logic [2:0] op;
      int r, n;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 0;
      @(negedge clk);
      chk("ready_after_init", snp_ready, 1);
      set_line(32'h0001_2340, 3, 2'd3);
      do_snoop(3'd1, 32'h0001_2340, 0);
      set_line(32'h0ABC_D09C, 0, 2'd2);
      do_snoop(3'd4, 32'h0ABC_D09C, 0);
      set_line(32'h1234_5678, -1, 2'd0);
      for (int w = 0; w < WAYS; w++) set_mesi[w] = 2'd0;
      do_snoop(3'd1, 32'h1234_5678, 0);
      set_line(32'h0000_1000, 5, 2'd2);
      do_snoop(3'd3, 32'h0000_1000, 0);
      set_line(32'h0F0F_0F00, 6, 2'd1);
      do_snoop(3'd1, 32'h0F0F_0F00, 0);
      set_line(32'h0F0F_0F00, 6, 2'd1);
      do_snoop(3'd3, 32'h0F0F_0F00, 0);
      set_line(32'h5555_5540, 2, 2'd1);
      do_snoop(3'd2, 32'h5555_5540, 0);
      set_line(32'hA0A0_0A00, 4, 2'd2);
      set_tag[9] = 12'hA0A;
      set_mesi[9] = 2'd3;
      do_snoop(3'd1, 32'hA0A0_0A00, 0);
      do_snoop(3'd0, 32'h1111_2222, 0);
      do_snoop(3'd7, 32'h3333_4444, 0);
      set_line(32'hFEDC_BA40, 7, 2'd3);
      hold_msg = 1;
      fork
         do_snoop(3'd4, 32'hFEDC_BA40, 0);
         begin
            n = 0;
            while (!msg_valid && n < 50) begin @(negedge clk); n++; end
            repeat (10) @(negedge clk);
            chk("stall_msg_code", msg_code, 1);
            hold_msg = 0;
         end
      join
      for (int i = 0; i < 60; i++) begin
         a = $urandom;
         r = $urandom_range(0, 9);
         op = r < 8 ? 3'(1 + r % 4) : (r == 8 ? 3'd0 : 3'($urandom_range(5, 7)));
         for (int w = 0; w < WAYS; w++) begin
            set_tag[w] = ($urandom_range(0, 15) == 0) ? a[31:20] : a[31:20] ^ 12'($urandom_range(1, 4095));
            set_mesi[w] = 2'($urandom);
         end
         do_snoop(op, a, 0);
      end
      set_line(32'h0001_2340, 3, 2'd3);
      hold_wb = 1;
      do_snoop(3'd1, 32'h0001_2340, 1);
      set_line(32'h0246_8AC0, 1, 2'd3);
      do_snoop(3'd1, 32'h0246_8AC0, 0);
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
